// File: rtl/rom_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : rom_burst_reader
// Description : Burst sequencer for a synchronous ROM with one-cycle read
//               latency. Delivers words in order on a valid/ready stream
//               through a 2-entry buffer with credit-based issue.
// Revision    : 1.0 - initial release
// ============================================================================
module rom_burst_reader #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic [ADDR_W:0]   burst_len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W:0]   remaining_q, remaining_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    logic              push_w;
    logic              pop_w;
    logic              issue_w;
    logic [2:0]        credit_w;

    assign pop_w  = (count_q != 2'd0) && out_ready_i;
    assign push_w = inflight_q;

    // Credits: buffered words plus the word still in the ROM pipeline,
    // minus the word leaving this edge, must leave room for one more.
    assign credit_w = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_w};
    assign issue_w  = (state_q == S_READ) && (remaining_q != '0) && (credit_w < 3'd2);

    assign count_d  = count_q + {1'b0, push_w} - {1'b0, pop_w};

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue_w;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && (burst_len_i != '0)) begin
                    rom_addr_d  = start_addr_i;
                    remaining_d = burst_len_i;
                    state_d     = S_READ;
                end
            end
            S_READ: begin
                if (issue_w) begin
                    rom_addr_d  = rom_addr_q + ADDR_ONE;
                    remaining_d = remaining_q - REM_ONE;
                    if (remaining_q == REM_ONE) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Leave once the buffer empties on this edge with nothing in flight.
                if ((count_d == 2'd0) && !inflight_d) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rom_addr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_w) begin
                mem_q[wr_ptr_q] <= rom_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_w) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = done_q;
    assign rom_addr_o  = rom_addr_q;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign out_valid_o = (count_q != 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_rom_burst_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rom_burst_reader
// Description : Scoreboard bench for rom_burst_reader with a behavioural ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rom_burst_reader;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] start_addr;
    logic [2:0] burst_len;
    logic       busy;
    logic       done;
    logic [1:0] rom_addr;
    logic [3:0] rom_data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [3:0] sb [$];

    logic [3:0] rom_tbl [4] = '{4'h3, 4'hC, 4'h5, 4'hA};

    rom_burst_reader #(.ADDR_W(2), .DATA_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start),
        .start_addr_i (start_addr),
        .burst_len_i  (burst_len),
        .busy_o       (busy),
        .done_o       (done),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial rom_data = 4'h0;
    always @(posedge clk) rom_data <= rom_tbl[rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        if (n > 0) sb.push_back(a);
        if (n > 1) sb.push_back(b);
        if (n > 2) sb.push_back(c);
        if (n > 3) sb.push_back(d);
    endtask

    task automatic issue_burst(input logic [1:0] addr, input logic [2:0] len);
        start      = 1'b1;
        start_addr = addr;
        burst_len  = len;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        logic got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check(name, got, 1'b1);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    logic       prev_stall = 1'b0;
    logic [3:0] prev_data  = 4'h0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid_hold", out_valid, 1'b1);
                check("stall_data_hold", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", out_data, 32'hFFFF_FFFF);
                end else begin
                    check("out_data", out_data, sb.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dc;
        int  pat [7] = '{1, 0, 0, 1, 0, 1, 1};
        logic got;
        logic busy_seen;

        rst        = 1'b1;
        start      = 1'b0;
        start_addr = 2'd0;
        burst_len  = 3'd0;
        out_ready  = 1'b1;

        #2;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rom_addr", rom_addr, 2'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 4'h0);
        step();
        step();
        rst = 1'b0;

        busy_seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busy || out_valid) busy_seen = 1'b1;
        end
        check("idle_quiet", busy_seen, 1'b0);
        step();

        // Full burst from address 0, exact cycle timing.
        push_exp(4, 4'h3, 4'hC, 4'h5, 4'hA);
        issue_burst(2'd0, 3'd4);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("full_valid_c%0d", c), out_valid, (c >= 3 && c <= 6));
            check($sformatf("full_done_c%0d", c), done, (c == 7));
            check($sformatf("full_busy_c%0d", c), busy, (c < 7));
            if (c <= 4) check($sformatf("full_addr_c%0d", c), rom_addr, c - 1);
        end
        check("full_sb_empty", sb.size(), 0);
        step();

        // Wrap-around burst, then a back-to-back burst launched in the done cycle.
        push_exp(3, 4'hA, 4'h3, 4'hC, 4'h0);
        issue_burst(2'd3, 3'd3);
        @(negedge clk);
        check("wrap_addr_1", rom_addr, 2'd3);
        @(negedge clk);
        check("wrap_addr_2", rom_addr, 2'd0);
        @(negedge clk);
        check("wrap_addr_3", rom_addr, 2'd1);
        wait_done("wrap_done", 20);
        push_exp(2, 4'h5, 4'hA, 4'h0, 4'h0);
        start      = 1'b1;
        start_addr = 2'd2;
        burst_len  = 3'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_busy", busy, 1'b1);
        check("b2b_addr", rom_addr, 2'd2);
        wait_done("b2b_done", 20);
        check("b2b_sb_empty", sb.size(), 0);
        step();

        // Backpressure with toggling ready.
        push_exp(4, 4'hC, 4'h5, 4'hA, 4'h3);
        issue_burst(2'd1, 3'd4);
        got = 1'b0;
        for (int c = 1; c < 40; c++) begin
            out_ready = (c < 3) ? 1'b1 : ((c - 3 < 7) ? pat[c-3][0] : 1'b1);
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check("bp_done", got, 1'b1);
        check("bp_sb_empty", sb.size(), 0);
        out_ready = 1'b1;
        step();

        // Zero-length request is ignored.
        dc = done_cnt;
        issue_burst(2'd1, 3'd0);
        busy_seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (busy || done || out_valid) busy_seen = 1'b1;
        end
        check("len0_ignored", busy_seen, 1'b0);
        check("len0_no_done", done_cnt, dc);
        step();

        // Start while busy is ignored.
        dc = done_cnt;
        push_exp(2, 4'h3, 4'hC, 4'h0, 4'h0);
        issue_burst(2'd0, 3'd2);
        start      = 1'b1;
        start_addr = 2'd3;
        burst_len  = 3'd4;
        step();
        step();
        start = 1'b0;
        wait_done("busy_start_done", 20);
        busy_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (busy || out_valid) busy_seen = 1'b1;
        end
        check("busy_start_no_second", busy_seen, 1'b0);
        check("busy_start_one_done", done_cnt, dc + 1);
        check("busy_start_sb_empty", sb.size(), 0);
        step();

        // Reset mid-burst after the second word is accepted.
        dc = done_cnt;
        push_exp(4, 4'h3, 4'hC, 4'h5, 4'hA);
        issue_burst(2'd0, 3'd4);
        step();
        step();
        step();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_two_accepted", sb.size(), 2);
        sb.delete();
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) @(negedge clk);
        check("midrst_no_done", done_cnt, dc);
        step();
        push_exp(1, 4'hC, 4'h0, 4'h0, 4'h0);
        issue_burst(2'd1, 3'd1);
        wait_done("post_rst_done", 20);
        for (int c = 0; c < 4; c++) @(negedge clk);
        check("post_rst_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
